// File: rtl/basic_gates_unit.sv
`default_nettype none
//============================================================================
// Module   : basic_gates_unit
// Purpose  : Registered bank of the seven basic two-input gate functions
//            (NOT a, AND, OR, NAND, NOR, XOR, XNOR) over WIDTH-bit operands.
//            Also provides a saturating accepted-sample counter and an
//            optional consistency checker with a sticky error flag.
// Revision : 1.0 - initial release
//
// Parameters
//   WIDTH     operand / result width (default 1)
//   CNT_W     accepted-sample counter width (default 16)
//
// Configuration macro
//   BASIC_GATES_SELFCHECK_EN  when defined, enables the output checker that
//                             drives err; otherwise err is tied to 0.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      capture a/b on this edge
//   a, b       in   WIDTH  operands
//   f          out  WIDTH  ~a            (registered)
//   y          out  WIDTH  a & b         (registered)
//   z          out  WIDTH  a | b         (registered)
//   w          out  WIDTH  ~(a & b)      (registered)
//   x          out  WIDTH  ~(a | b)      (registered)
//   c          out  WIDTH  a ^ b         (registered)
//   g          out  WIDTH  ~(a ^ b)      (registered)
//   out_valid  out  1      f..g updated on the previous edge
//   count      out  CNT_W  accepted samples, saturating
//   err        out  1      sticky checker failure flag
//============================================================================
module basic_gates_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] g,
    output logic             out_valid,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // Combinational gate results of the current operands
    logic [WIDTH-1:0] w_not;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] w_nor;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_xnor;

    assign w_not  = ~a;
    assign w_and  = a & b;
    assign w_or   = a | b;
    assign w_nand = ~w_and;
    assign w_nor  = ~w_or;
    assign w_xor  = a ^ b;
    assign w_xnor = ~w_xor;

    logic [WIDTH-1:0] r_f;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_w;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_g;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_w         <= '0;
            r_x         <= '0;
            r_c         <= '0;
            r_g         <= '0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_f <= w_not;
                r_y <= w_and;
                r_z <= w_or;
                r_w <= w_nand;
                r_x <= w_nor;
                r_c <= w_xor;
                r_g <= w_xnor;
                // Saturate rather than wrap; the gate outputs above still
                // load on the accept that hits the maximum.
                if (r_count != c_CNT_MAX) begin
                    r_count <= r_count + c_CNT_ONE;
                end
            end
        end
    end

    assign f         = r_f;
    assign y         = r_y;
    assign z         = r_z;
    assign w         = r_w;
    assign x         = r_x;
    assign c         = r_c;
    assign g         = r_g;
    assign out_valid = r_out_valid;
    assign count     = r_count;

`ifdef BASIC_GATES_SELFCHECK_EN
    // Cross-checks relations that must hold between the registered results;
    // (y | c) == z holds because AND and XOR partition the OR.
    logic w_chk_fail;
    logic r_err;

    assign w_chk_fail = r_out_valid &&
                        ((r_w != ~r_y) ||
                         (r_x != ~r_z) ||
                         (r_g != ~r_c) ||
                         ((r_y | r_c) != r_z));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_chk_fail) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_basic_gates_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_basic_gates_unit
// Purpose  : Self-checking bench for basic_gates_unit. Instance u_dut0 uses
//            WIDTH=1/CNT_W=16 for the truth-table vectors; u_dut1 uses
//            WIDTH=8/CNT_W=3 for counter saturation and random traffic
//            checked against a behavioural model.
// Revision : 1.0 - initial release
//============================================================================
module tb_basic_gates_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance 0: WIDTH=1, CNT_W=16
    logic        v0;
    logic [0:0]  a0, b0;
    logic [0:0]  f0, y0, z0, w0, x0, c0, g0;
    logic        ov0;
    logic [15:0] cnt0;
    logic        err0;

    // Instance 1: WIDTH=8, CNT_W=3
    logic        v1;
    logic [7:0]  a1, b1;
    logic [7:0]  f1, y1, z1, w1, x1, c1, g1;
    logic        ov1;
    logic [2:0]  cnt1;
    logic        err1;

    basic_gates_unit #(.WIDTH(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .a(a0), .b(b0),
        .f(f0), .y(y0), .z(z0), .w(w0), .x(x0), .c(c0), .g(g0),
        .out_valid(ov0), .count(cnt0), .err(err0)
    );

    basic_gates_unit #(.WIDTH(8), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
        .f(f1), .y(y1), .z(z1), .w(w1), .x(x1), .c(c1), .g(g1),
        .out_valid(ov1), .count(cnt1), .err(err1)
    );

    int total = 0;
    int bad   = 0;

    // Expected {f,y,z,w,x,c,g} for WIDTH=1, indexed by {a,b}
    logic [6:0] tbl [4] = '{7'b1001101, 7'b1011010, 7'b0011010, 7'b0110001};

    // Behavioural model for instance 1
    logic [55:0] m_gates;
    logic        m_ov;
    int          m_cnt;

    function automatic logic [6:0] gates0();
        return {f0, y0, z0, w0, x0, c0, g0};
    endfunction

    function automatic logic [55:0] gates1();
        return {f1, y1, z1, w1, x1, c1, g1};
    endfunction

    task automatic model_reset();
        m_gates = '0;
        m_ov    = 1'b0;
        m_cnt   = 0;
    endtask

    // Advance the model by one edge given the inputs applied to instance 1
    task automatic model_step(input logic v, input logic [7:0] a, input logic [7:0] b);
        m_ov = v;
        if (v) begin
            m_gates = {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
            if (m_cnt < 7) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_model(input string tag);
        total++;
        if (gates1() !== m_gates) begin
            bad++;
            $display("FAIL %s gates: got %h want %h", tag, gates1(), m_gates);
        end
        total++;
        if (ov1 !== m_ov) begin
            bad++;
            $display("FAIL %s out_valid: got %b want %b", tag, ov1, m_ov);
        end
        total++;
        if (cnt1 !== 3'(m_cnt)) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d", tag, cnt1, m_cnt);
        end
        total++;
        if (err1 !== 1'b0) begin
            bad++;
            $display("FAIL %s err: got %b want 0", tag, err1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({gates0(), ov0, cnt0, err0} !== '0) begin
            bad++;
            $display("FAIL %s dut0: got %h want 0", tag, {gates0(), ov0, cnt0, err0});
        end
        total++;
        if ({gates1(), ov1, cnt1, err1} !== '0) begin
            bad++;
            $display("FAIL %s dut1: got %h want 0", tag, {gates1(), ov1, cnt1, err1});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v0 = 1'b0; a0 = '0; b0 = '0;
        v1 = 1'b0; a1 = '0; b1 = '0;
        model_reset();
        #2;
        check_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_clocked");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v0 = 1'b1;
            a0 = 1'(i >> 1);
            b0 = 1'(i);
            @(posedge clk);
            #1;
            total++;
            if (gates0() !== tbl[i]) begin
                bad++;
                $display("FAIL truth_%0d: got %b want %b", i, gates0(), tbl[i]);
            end
            total++;
            if (ov0 !== 1'b1) begin
                bad++;
                $display("FAIL truth_ov_%0d: got %b want 1", i, ov0);
            end
        end
        @(negedge clk);
        v0 = 1'b0;
        total++;
        if (cnt0 !== 16'd4) begin
            bad++;
            $display("FAIL truth_count: got %0d want 4", cnt0);
        end
        @(posedge clk);
        #1;
        total++;
        if (err0 !== 1'b0 || ov0 !== 1'b0) begin
            bad++;
            $display("FAIL truth_err_ov: got err=%b ov=%b want 0 0", err0, ov0);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        v0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a0 = 1'(k);
            b0 = 1'(k >> 1);
            @(posedge clk);
            #1;
            total++;
            if (gates0() !== tbl[3] || ov0 !== 1'b0 || cnt0 !== 16'd5) begin
                bad++;
                $display("FAIL hold_%0d: got gates=%b ov=%b cnt=%0d want %b 0 5",
                         k, gates0(), ov0, cnt0, tbl[3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        v0 = 1'b1; a0 = 1'b0; b0 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ov0 !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_ov: got %b want 1", ov0);
        end
        // Sample in flight on the inputs while reset pulses between edges
        a0 = 1'b1; b0 = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("midstream_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_held_edge");
        @(negedge clk);
        rst_n = 1'b1;
        v0 = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("post_reset_idle");
        @(negedge clk);
        v0 = 1'b1; a0 = 1'b0; b0 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (gates0() !== tbl[1] || ov0 !== 1'b1 || cnt0 !== 16'd1) begin
            bad++;
            $display("FAIL first_after_reset: got gates=%b ov=%b cnt=%0d want %b 1 1",
                     gates0(), ov0, cnt0, tbl[1]);
        end
        @(negedge clk);
        v0 = 1'b0;
    endtask

    // Ten consecutive accepts on the 3-bit counter instance, then idle
    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            v1 = 1'b1;
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            model_step(v1, a1, b1);
            @(posedge clk);
            #1;
            check_model("b2b");
        end
        @(negedge clk);
        v1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            model_step(v1, a1, b1);
            @(posedge clk);
            #1;
            total++;
            if (cnt1 !== 3'd7) begin
                bad++;
                $display("FAIL sat_hold_%0d: got %0d want 7", k, cnt1);
            end
            check_model("sat_idle");
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            v1 = 1'($urandom_range(0, 3) != 0);
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            model_step(v1, a1, b1);
            @(posedge clk);
            #1;
            check_model("random");
            @(negedge clk);
        end
        v1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
